// File: rtl/branch_seq_pkg.sv
// branch_seq_pkg: shared definitions for the EX branch sequencer.
//   - br_kind encodings (3 bits; 6 and 7 are illegal)
//   - sequencer state encoding
//   - quick-compare select constants and the kind -> select mapping
package branch_seq_pkg;

  localparam logic [2:0] BR_NE  = 3'd0;
  localparam logic [2:0] BR_EQ  = 3'd1;
  localparam logic [2:0] BR_LEZ = 3'd2;
  localparam logic [2:0] BR_GTZ = 3'd3;
  localparam logic [2:0] BR_GEZ = 3'd4;
  localparam logic [2:0] BR_LTZ = 3'd5;

  // Compare selects driven to the qc unit (select_qc_* encodings).
  localparam logic [5:0] SELECT_QC_NE  = 6'b000001;
  localparam logic [5:0] SELECT_QC_EQ  = 6'b000010;
  localparam logic [5:0] SELECT_QC_LEZ = 6'b000100;
  localparam logic [5:0] SELECT_QC_GTZ = 6'b001000;
  localparam logic [5:0] SELECT_QC_GEZ = 6'b010000;
  localparam logic [5:0] SELECT_QC_LTZ = 6'b100000;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_OPND = 2'd1,
    ST_EVAL      = 2'd2,
    ST_REDIRECT  = 2'd3
  } state_e;

  function automatic logic kind_legal(input logic [2:0] kind);
    return kind <= BR_LTZ;
  endfunction

  function automatic logic [5:0] kind_to_sel(input logic [2:0] kind);
    logic [5:0] sel;
    case (kind)
      BR_NE:   sel = SELECT_QC_NE;
      BR_EQ:   sel = SELECT_QC_EQ;
      BR_LEZ:  sel = SELECT_QC_LEZ;
      BR_GTZ:  sel = SELECT_QC_GTZ;
      BR_GEZ:  sel = SELECT_QC_GEZ;
      BR_LTZ:  sel = SELECT_QC_LTZ;
      default: sel = SELECT_QC_NE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/branch_seq_stats.sv
// branch_stats: three saturating event counters for the branch sequencer.
// Ports:
//   clk, reset_n          clock, async active-low reset (counters clear only here)
//   inc_taken/ntaken/stall one-cycle increment strobes
//   stat_taken/ntaken/stall counter values, saturate at all-ones
module branch_stats #(
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              inc_taken,
  input  logic              inc_ntaken,
  input  logic              inc_stall,
  output logic [STAT_W-1:0] stat_taken,
  output logic [STAT_W-1:0] stat_ntaken,
  output logic [STAT_W-1:0] stat_stall
);

  logic [STAT_W-1:0] taken_q, taken_d;
  logic [STAT_W-1:0] ntaken_q, ntaken_d;
  logic [STAT_W-1:0] stall_q, stall_d;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v, input logic en);
    if (en && (v != {STAT_W{1'b1}})) return v + STAT_W'(1);
    return v;
  endfunction

  always_comb begin
    taken_d  = sat_inc(taken_q, inc_taken);
    ntaken_d = sat_inc(ntaken_q, inc_ntaken);
    stall_d  = sat_inc(stall_q, inc_stall);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      taken_q  <= '0;
      ntaken_q <= '0;
      stall_q  <= '0;
    end else begin
      taken_q  <= taken_d;
      ntaken_q <= ntaken_d;
      stall_q  <= stall_d;
    end
  end

  assign stat_taken  = taken_q;
  assign stat_ntaken = ntaken_q;
  assign stat_stall  = stall_q;

endmodule

// File: rtl/branch_seq.sv
// branch_seq: sequences conditional-branch resolution in EX around the
// quick-compare (qc) unit.
// Inputs : clk, reset_n (async active-low), br_req, br_kind[2:0],
//          br_target[31:0], opnd_ready, qc_result, fetch_ready
// Outputs: qc_sel[5:0], stall_ex, redirect_valid, redirect_pc[31:0],
//          br_illegal / br_timeout (one-cycle pulses),
//          stat_taken/stat_ntaken/stat_stall[STAT_W-1:0],
//          dbg_state (current sequencer state)
// Handshake: a redirect transfers on any rising edge where redirect_valid
// and fetch_ready are both 1; redirect_valid and redirect_pc do not change
// until that edge, and redirect_valid drops the following cycle.
// Optional feature: define BRANCH_STATS_EN to build the statistics counters;
// otherwise the stat_* outputs are tied to 0.
module branch_seq
  import branch_seq_pkg::*;
#(
  parameter int WAIT_MAX = 15,
  parameter int STAT_W   = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              br_req,
  input  logic [2:0]        br_kind,
  input  logic [31:0]       br_target,
  input  logic              opnd_ready,
  input  logic              qc_result,
  input  logic              fetch_ready,
  output logic [5:0]        qc_sel,
  output logic              stall_ex,
  output logic              redirect_valid,
  output logic [31:0]       redirect_pc,
  output logic              br_illegal,
  output logic              br_timeout,
  output logic [STAT_W-1:0] stat_taken,
  output logic [STAT_W-1:0] stat_ntaken,
  output logic [STAT_W-1:0] stat_stall,
  output state_e            dbg_state
);

  localparam int CNT_W = $clog2(WAIT_MAX + 1);
  // Last counter value before the increment that reaches WAIT_MAX.
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_MAX - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [5:0]        qc_sel_q, qc_sel_d;
  logic [31:0]       target_q, target_d;
  logic [31:0]       redirect_pc_q, redirect_pc_d;
  logic              br_illegal_q, br_illegal_d;
  logic              br_timeout_q, br_timeout_d;

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    qc_sel_d      = qc_sel_q;
    target_d      = target_q;
    redirect_pc_d = redirect_pc_q;
    br_illegal_d  = 1'b0;
    br_timeout_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (br_req) begin
          if (kind_legal(br_kind)) begin
            target_d   = br_target;
            qc_sel_d   = kind_to_sel(br_kind);
            wait_cnt_d = '0;
            state_d    = opnd_ready ? ST_EVAL : ST_WAIT_OPND;
          end else begin
            br_illegal_d = 1'b1;
          end
        end
      end
      ST_WAIT_OPND: begin
        wait_cnt_d = wait_cnt_q + CNT_W'(1);
        // opnd_ready takes priority over the abort on the final cycle.
        if (opnd_ready) begin
          state_d = ST_EVAL;
        end else if (wait_cnt_q == WAIT_LAST) begin
          br_timeout_d = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      ST_EVAL: begin
        if (qc_result) begin
          redirect_pc_d = target_q;
          state_d       = ST_REDIRECT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REDIRECT: begin
        if (fetch_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      wait_cnt_q    <= '0;
      qc_sel_q      <= SELECT_QC_NE;
      target_q      <= '0;
      redirect_pc_q <= '0;
      br_illegal_q  <= 1'b0;
      br_timeout_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      qc_sel_q      <= qc_sel_d;
      target_q      <= target_d;
      redirect_pc_q <= redirect_pc_d;
      br_illegal_q  <= br_illegal_d;
      br_timeout_q  <= br_timeout_d;
    end
  end

  assign qc_sel         = qc_sel_q;
  assign stall_ex       = (state_q != ST_IDLE);
  assign redirect_valid = (state_q == ST_REDIRECT);
  assign redirect_pc    = redirect_pc_q;
  assign br_illegal     = br_illegal_q;
  assign br_timeout     = br_timeout_q;
  assign dbg_state      = state_q;

`ifdef BRANCH_STATS_EN
  branch_stats #(.STAT_W(STAT_W)) u_stats (
    .clk         (clk),
    .reset_n     (reset_n),
    .inc_taken   ((state_q == ST_EVAL) && qc_result),
    .inc_ntaken  ((state_q == ST_EVAL) && !qc_result),
    .inc_stall   (stall_ex),
    .stat_taken  (stat_taken),
    .stat_ntaken (stat_ntaken),
    .stat_stall  (stat_stall)
  );
`else
  assign stat_taken  = '0;
  assign stat_ntaken = '0;
  assign stat_stall  = '0;
`endif

endmodule

// File: tb/tb_branch_seq.sv
// tb_branch_seq: directed table-driven bench for branch_seq plus hand-written
// sequences for operand-wait timeout and reset during a redirect.
module tb_branch_seq;
  import branch_seq_pkg::*;

  localparam int STAT_W = 16;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              br_req;
  logic [2:0]        br_kind;
  logic [31:0]       br_target;
  logic              opnd_ready;
  logic              qc_result;
  logic              fetch_ready;
  logic [5:0]        qc_sel;
  logic              stall_ex;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              br_illegal;
  logic              br_timeout;
  logic [STAT_W-1:0] stat_taken;
  logic [STAT_W-1:0] stat_ntaken;
  logic [STAT_W-1:0] stat_stall;
  state_e            dbg_state;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  branch_seq #(.WAIT_MAX(15), .STAT_W(STAT_W)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .br_req         (br_req),
    .br_kind        (br_kind),
    .br_target      (br_target),
    .opnd_ready     (opnd_ready),
    .qc_result      (qc_result),
    .fetch_ready    (fetch_ready),
    .qc_sel         (qc_sel),
    .stall_ex       (stall_ex),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .br_illegal     (br_illegal),
    .br_timeout     (br_timeout),
    .stat_taken     (stat_taken),
    .stat_ntaken    (stat_ntaken),
    .stat_stall     (stat_stall),
    .dbg_state      (dbg_state)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic req, input logic [2:0] kind, input logic [31:0] tgt,
                       input logic opnd, input logic qc, input logic fr);
    br_req      = req;
    br_kind     = kind;
    br_target   = tgt;
    opnd_ready  = opnd;
    qc_result   = qc;
    fetch_ready = fr;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        req;
    logic [2:0]  kind;
    logic [31:0] tgt;
    logic        opnd;
    logic        qc;
    logic        fr;
    logic        stall;
    logic        rv;
    logic [31:0] pc;
    logic [5:0]  sel;
    logic        ill;
    logic        to;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic req, logic [2:0] kind, logic [31:0] tgt, logic opnd,
                              logic qc, logic fr, logic stall, logic rv, logic [31:0] pc,
                              logic [5:0] sel, logic ill, logic to);
    vec_t v;
    v.req = req; v.kind = kind; v.tgt = tgt; v.opnd = opnd; v.qc = qc; v.fr = fr;
    v.stall = stall; v.rv = rv; v.pc = pc; v.sel = sel; v.ill = ill; v.to = to;
    return v;
  endfunction

  localparam logic [31:0] TA = 32'h0040_0100;
  localparam logic [31:0] TC = 32'h0040_0300;
  localparam logic [31:0] TE = 32'h0040_1000;

  initial begin
    int exp_stall_cycles;
    int to_pulses;
    int to_cycle;
    int rv_seen;

    reset_n = 1'b0;
    drive(0, 3'd0, 32'd0, 0, 0, 0);
    step();
    step();
    // reset state
    chk("rst_stall", 32'(stall_ex), 32'd0);
    chk("rst_rv", 32'(redirect_valid), 32'd0);
    chk("rst_pc", redirect_pc, 32'd0);
    chk("rst_sel", 32'(qc_sel), 32'(SELECT_QC_NE));
    chk("rst_ill", 32'(br_illegal), 32'd0);
    chk("rst_to", 32'(br_timeout), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    reset_n = 1'b1;
    step();

    // ---- table: req kind tgt opnd qc fr | stall rv pc sel ill to ----
    // taken EQ, operands ready, fetch ready
    tbl.push_back(mk(1, 3'd1, TA, 1, 0, 0,  0, 0, 32'd0, SELECT_QC_NE, 0, 0));
    tbl.push_back(mk(0, 3'd0, 0,  0, 1, 1,  1, 0, 32'd0, SELECT_QC_EQ, 0, 0));
    tbl.push_back(mk(0, 3'd0, 0,  0, 0, 1,  1, 1, TA,    SELECT_QC_EQ, 0, 0));
    tbl.push_back(mk(0, 3'd0, 0,  0, 0, 0,  0, 0, TA,    SELECT_QC_EQ, 0, 0));
    // not-taken GTZ
    tbl.push_back(mk(1, 3'd3, 32'h0040_0200, 1, 0, 0,  0, 0, TA, SELECT_QC_EQ, 0, 0));
    tbl.push_back(mk(0, 3'd0, 0,  0, 0, 0,  1, 0, TA, SELECT_QC_GTZ, 0, 0));
    tbl.push_back(mk(0, 3'd0, 0,  0, 0, 0,  0, 0, TA, SELECT_QC_GTZ, 0, 0));
    // NE: operand wait 3 cycles, then 2 cycles of fetch backpressure
    tbl.push_back(mk(1, 3'd0, TC, 0, 0, 0,  0, 0, TA, SELECT_QC_GTZ, 0, 0));
    tbl.push_back(mk(0, 3'd0, 0,  0, 0, 0,  1, 0, TA, SELECT_QC_NE, 0, 0));
    tbl.push_back(mk(0, 3'd0, 0,  0, 0, 0,  1, 0, TA, SELECT_QC_NE, 0, 0));
    tbl.push_back(mk(0, 3'd0, 0,  1, 0, 0,  1, 0, TA, SELECT_QC_NE, 0, 0));
    tbl.push_back(mk(0, 3'd0, 0,  0, 1, 0,  1, 0, TA, SELECT_QC_NE, 0, 0));
    tbl.push_back(mk(0, 3'd0, 0,  0, 0, 0,  1, 1, TC, SELECT_QC_NE, 0, 0));
    tbl.push_back(mk(0, 3'd0, 0,  0, 0, 0,  1, 1, TC, SELECT_QC_NE, 0, 0));
    tbl.push_back(mk(0, 3'd0, 0,  0, 0, 1,  1, 1, TC, SELECT_QC_NE, 0, 0));
    tbl.push_back(mk(0, 3'd0, 0,  0, 0, 0,  0, 0, TC, SELECT_QC_NE, 0, 0));
    // illegal kind 7
    tbl.push_back(mk(1, 3'd7, 32'hdead_0000, 1, 0, 0,  0, 0, TC, SELECT_QC_NE, 0, 0));
    tbl.push_back(mk(0, 3'd0, 0,  0, 0, 0,  0, 0, TC, SELECT_QC_NE, 1, 0));
    tbl.push_back(mk(0, 3'd0, 0,  0, 0, 0,  0, 0, TC, SELECT_QC_NE, 0, 0));
    // taken LTZ then back-to-back not-taken GEZ
    tbl.push_back(mk(1, 3'd5, TE, 1, 0, 0,  0, 0, TC, SELECT_QC_NE, 0, 0));
    tbl.push_back(mk(0, 3'd0, 0,  0, 1, 1,  1, 0, TC, SELECT_QC_LTZ, 0, 0));
    tbl.push_back(mk(0, 3'd0, 0,  0, 0, 1,  1, 1, TE, SELECT_QC_LTZ, 0, 0));
    tbl.push_back(mk(1, 3'd4, 32'h0040_2000, 1, 0, 0,  0, 0, TE, SELECT_QC_LTZ, 0, 0));
    tbl.push_back(mk(0, 3'd0, 0,  0, 0, 0,  1, 0, TE, SELECT_QC_GEZ, 0, 0));
    tbl.push_back(mk(0, 3'd0, 0,  0, 0, 0,  0, 0, TE, SELECT_QC_GEZ, 0, 0));
    // not-taken LEZ; an illegal br_req during EVAL is ignored
    tbl.push_back(mk(1, 3'd2, 32'h0040_3000, 1, 0, 0,  0, 0, TE, SELECT_QC_GEZ, 0, 0));
    tbl.push_back(mk(1, 3'd7, 0,  1, 0, 0,  1, 0, TE, SELECT_QC_LEZ, 0, 0));
    tbl.push_back(mk(0, 3'd0, 0,  0, 0, 0,  0, 0, TE, SELECT_QC_LEZ, 0, 0));

    exp_stall_cycles = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].req, tbl[i].kind, tbl[i].tgt, tbl[i].opnd, tbl[i].qc, tbl[i].fr);
      chk($sformatf("v%0d_stall", i), 32'(stall_ex), 32'(tbl[i].stall));
      chk($sformatf("v%0d_rv", i), 32'(redirect_valid), 32'(tbl[i].rv));
      chk($sformatf("v%0d_pc", i), redirect_pc, tbl[i].pc);
      chk($sformatf("v%0d_sel", i), 32'(qc_sel), 32'(tbl[i].sel));
      chk($sformatf("v%0d_ill", i), 32'(br_illegal), 32'(tbl[i].ill));
      chk($sformatf("v%0d_to", i), 32'(br_timeout), 32'(tbl[i].to));
      if (tbl[i].stall) exp_stall_cycles++;
      step();
    end

`ifdef BRANCH_STATS_EN
    chk("stat_taken", 32'(stat_taken), 32'd3);
    chk("stat_ntaken", 32'(stat_ntaken), 32'd3);
    chk("stat_stall", 32'(stat_stall), 32'(exp_stall_cycles));
`else
    chk("stat_taken_off", 32'(stat_taken), 32'd0);
    chk("stat_ntaken_off", 32'(stat_ntaken), 32'd0);
    chk("stat_stall_off", 32'(stat_stall), 32'd0);
`endif

    // ---- operand-wait timeout: opnd_ready low for 20 cycles ----
    to_pulses = 0;
    to_cycle  = -1;
    rv_seen   = 0;
    drive(1, 3'd1, TA, 0, 1, 1);
    step();
    for (int c = 1; c <= 20; c++) begin
      drive(0, 3'd0, 32'd0, 0, 1, 1);
      if (br_timeout) begin
        to_pulses++;
        to_cycle = c;
      end
      if (redirect_valid) rv_seen++;
      step();
    end
    chk("to_pulses", 32'(to_pulses), 32'd1);
    chk("to_cycle", 32'(to_cycle), 32'd16);
    chk("to_no_redirect", 32'(rv_seen), 32'd0);
    chk("to_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("to_stall", 32'(stall_ex), 32'd0);

    // ---- reset asserted while a redirect is pending ----
    drive(1, 3'd1, TA, 1, 0, 0);
    step();
    drive(0, 3'd0, 32'd0, 0, 1, 0);
    step();
    drive(0, 3'd0, 32'd0, 0, 0, 0);
    chk("rr_pre_rv", 32'(redirect_valid), 32'd1);
    chk("rr_pre_pc", redirect_pc, TA);
    reset_n = 1'b0;
    #1;
    chk("rr_stall", 32'(stall_ex), 32'd0);
    chk("rr_rv", 32'(redirect_valid), 32'd0);
    chk("rr_pc", redirect_pc, 32'd0);
    chk("rr_sel", 32'(qc_sel), 32'(SELECT_QC_NE));
    chk("rr_ill", 32'(br_illegal), 32'd0);
    chk("rr_to", 32'(br_timeout), 32'd0);
    chk("rr_stat_taken", 32'(stat_taken), 32'd0);
    chk("rr_stat_stall", 32'(stat_stall), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    chk("rr_post_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("rr_post_rv", 32'(redirect_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
